// File: rtl/mmio_reduce_unit.sv
// mmio_reduce_unit: address-mapped reduction engine.
// The host pushes operands into N_CH input FIFOs through the write port.
// Whenever every channel holds an operand and the result FIFO has room, one
// operand is popped from each channel. The operands are reduced with
// OR/AND/XOR/ADD, and the result is queued for the host to read.
// Ports:
//   CLK, RST_N                    clock, synchronous active-low reset
//   write_address/data/en, _rdy   register write port (rdy tied 1)
//   read_address/en, read_data    register read port; read_en at 3 pops
//   read_rdy                      tied 1

// In-order FIFO. The full/empty flags come from a registered count, so a
// push or pop in a given cycle only sees the state after the previous edge.
module mmio_reduce_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_cnt == CW'(D));
  assign o_empty   = (r_cnt == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd];

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge CLK)
    if (w_push_ok) r_mem[r_wr] <= i_din;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= (r_wr == AW'(D - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= (r_rd == AW'(D - 1)) ? '0 : r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module mmio_reduce_unit #(
  parameter int WIDTH     = 8,
  parameter int N_CH      = 2,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [3:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy
);
  logic [N_CH-1:0][WIDTH-1:0] w_ch_head;
  logic [N_CH-1:0]            w_ch_full, w_ch_empty, w_ch_push;
  logic [WIDTH-1:0]           w_res_head, w_reduced, w_rd;
  logic                       w_res_full, w_res_empty;
  logic                       w_comb, w_res_pop, w_rd3, w_st_wr;
  logic [1:0]                 r_mode;
  logic [WIDTH-1:0]           r_count;
  logic                       r_ovf, r_unf;

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  // Both terms come from registered flags, so the combine never bypasses
  // a push or pop that happens on the same edge.
  assign w_comb    = (&(~w_ch_empty)) && !w_res_full;
  assign w_rd3     = read_en && (read_address == 4'd3);
  assign w_res_pop = w_rd3 && !w_res_empty;
  assign w_st_wr   = write_en && (write_address == 4'd2);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_ch_push[i] = write_en && (write_address == 4'(8 + i));
    mmio_reduce_fifo #(.W(WIDTH), .D(IN_DEPTH)) u_fifo (
      .CLK(CLK), .RST_N(RST_N),
      .i_push(w_ch_push[i]), .i_pop(w_comb), .i_din(write_data),
      .o_dout(w_ch_head[i]), .o_full(w_ch_full[i]), .o_empty(w_ch_empty[i])
    );
  end

  mmio_reduce_fifo #(.W(WIDTH), .D(OUT_DEPTH)) u_res (
    .CLK(CLK), .RST_N(RST_N),
    .i_push(w_comb), .i_pop(w_res_pop), .i_din(w_reduced),
    .o_dout(w_res_head), .o_full(w_res_full), .o_empty(w_res_empty)
  );

  // Fold channel 0 with the rest; with N_CH=1 the operand passes through.
  always_comb begin
    w_reduced = w_ch_head[0];
    for (int i = 1; i < N_CH; i++) begin
      case (r_mode)
        2'd0:    w_reduced = w_reduced | w_ch_head[i];
        2'd1:    w_reduced = w_reduced & w_ch_head[i];
        2'd2:    w_reduced = w_reduced ^ w_ch_head[i];
        default: w_reduced = w_reduced + w_ch_head[i];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_mode  <= 2'd0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (write_en && (write_address == 4'd4)) r_mode <= write_data[1:0];
      if (w_comb) r_count <= r_count + WIDTH'(1);
      // A new event on the clearing edge keeps the sticky bit set.
      if (w_st_wr && write_data[2]) r_ovf <= 1'b0;
      if (w_st_wr && write_data[3]) r_unf <= 1'b0;
      if (|(w_ch_push & w_ch_full)) r_ovf <= 1'b1;
      if (w_rd3 && w_res_empty)     r_unf <= 1'b1;
    end
  end

  always_comb begin
    w_rd = '0;
    case (read_address)
      4'd0: w_rd[N_CH-1:0] = ~w_ch_full;
      4'd1: w_rd[N_CH-1:0] = ~w_ch_empty;
      4'd2: w_rd[3:0]      = {r_unf, r_ovf, ~w_res_full, ~w_res_empty};
      4'd3: w_rd           = w_res_empty ? '0 : w_res_head;
      4'd4: w_rd[1:0]      = r_mode;
      4'd5: w_rd           = r_count;
      default: w_rd = '0;
    endcase
  end
  assign read_data = w_rd;
endmodule

// File: tb/tb_mmio_reduce_unit.sv
// Directed bench for mmio_reduce_unit at default parameters
// (WIDTH=8, N_CH=2, IN_DEPTH=2, OUT_DEPTH=2).
module tb_mmio_reduce_unit;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] write_address, read_address;
  logic [7:0] write_data, read_data;
  logic       write_en, read_en, write_rdy, read_rdy;
  int         n_pass = 0, n_tot = 0;

  mmio_reduce_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    write_address = a; write_data = d; write_en = 1'b1;
    @(posedge CLK); #1;
    write_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    read_address = a; #1;
    check(tag, read_data, exp);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    read_address = 4'd3; read_en = 1'b1; #1;
    check(tag, read_data, exp);
    @(posedge CLK); #1;
    read_en = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; write_en = 1'b0; read_en = 1'b0;
    write_address = '0; write_data = '0; read_address = '0;
    idle(2);
    check("rdy_in_reset", {6'd0, write_rdy, read_rdy}, 8'h03);
    RST_N = 1'b1;
    rd("rst_a0", 4'd0, 8'h03);
    rd("rst_a1", 4'd1, 8'h00);
    rd("rst_a2", 4'd2, 8'h02);
    rd("rst_a4", 4'd4, 8'h00);
    rd("rst_a5", 4'd5, 8'h00);

    // OR
    wr(4'd8, 8'h0F);
    rd("or_a1_ch0", 4'd1, 8'h01);
    wr(4'd9, 8'hF0);
    rd("or_a1_both", 4'd1, 8'h03);
    idle(1);
    rd("or_a1_popped", 4'd1, 8'h00);
    rd("or_a2_ready", 4'd2, 8'h03);
    pop("or_res", 8'hFF);
    rd("or_cnt", 4'd5, 8'h01);
    rd("or_a2_empty", 4'd2, 8'h02);

    // AND / XOR / ADD
    wr(4'd4, 8'h01); wr(4'd8, 8'hC3); wr(4'd9, 8'h81); idle(1);
    pop("and_res", 8'h81);
    wr(4'd4, 8'h02); wr(4'd8, 8'hC3); wr(4'd9, 8'h81); idle(1);
    pop("xor_res", 8'h42);
    wr(4'd4, 8'h03); wr(4'd8, 8'hC3); wr(4'd9, 8'h81); idle(1);
    pop("add_res", 8'h44);
    rd("mode_rb", 4'd4, 8'h03);

    // Mode written on the combine edge: combine still uses ADD
    wr(4'd8, 8'hC3); wr(4'd9, 8'h81); wr(4'd4, 8'h01);
    pop("mode_late", 8'h44);
    // Mode written between pushes: combine uses the new mode (XOR)
    wr(4'd8, 8'hC3); wr(4'd4, 8'h02); wr(4'd9, 8'h81); idle(1);
    pop("mode_early", 8'h42);
    rd("cnt6", 4'd5, 8'h06);

    // Overflow on ch0
    wr(4'd8, 8'h01); wr(4'd8, 8'h02); wr(4'd8, 8'h03);
    rd("ovf_a0", 4'd0, 8'h02);
    rd("ovf_set", 4'd2, 8'h06);
    wr(4'd2, 8'h04);
    rd("ovf_clr", 4'd2, 8'h02);
    wr(4'd9, 8'h10); wr(4'd9, 8'h20); idle(1);
    rd("res_full", 4'd2, 8'h01);
    pop("ovf_r1", 8'h11);
    pop("ovf_r2", 8'h22);
    rd("ovf_dropped", 4'd1, 8'h00);

    // Underflow
    pop("unf_rd", 8'h00);
    rd("unf_set", 4'd2, 8'h0A);
    wr(4'd2, 8'h08);
    rd("unf_clr", 4'd2, 8'h02);

    // Back-to-back combines fill the result FIFO, then stall
    wr(4'd4, 8'h00);
    wr(4'd8, 8'h01); wr(4'd8, 8'h02); wr(4'd9, 8'h10); wr(4'd9, 8'h20);
    wr(4'd8, 8'h04); wr(4'd9, 8'h40); idle(1);
    rd("stall_held", 4'd1, 8'h03);
    rd("stall_full", 4'd2, 8'h01);
    rd("stall_cnt", 4'd5, 8'h0A);
    pop("stall_pop", 8'h11);
    rd("stall_no_bypass", 4'd1, 8'h03);
    idle(1);
    rd("stall_fired", 4'd1, 8'h00);
    rd("stall_cnt2", 4'd5, 8'h0B);

    // Reset with queued results and a pending operand
    wr(4'd8, 8'h77);
    RST_N = 1'b0; idle(1); RST_N = 1'b1;
    rd("rst2_a0", 4'd0, 8'h03);
    rd("rst2_a1", 4'd1, 8'h00);
    rd("rst2_a2", 4'd2, 8'h02);
    rd("rst2_a4", 4'd4, 8'h00);
    rd("rst2_cnt", 4'd5, 8'h00);
    wr(4'd15, 8'hFF);
    rd("unmapped_wr", 4'd1, 8'h00);
    rd("unmapped_rd", 4'd6, 8'h00);
    wr(4'd8, 8'h0A); wr(4'd9, 8'h50); idle(1);
    pop("post_rst", 8'h5A);
    rd("post_rst_a2", 4'd2, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
